// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, state encoding and index helpers
// for the systolic matrix result path.
package matrix_pkg;

    localparam int MAT_DIM = 3;
    localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
    localparam int FP8_W = 8;
    localparam int FP8_EXP_BIAS = 3;
    localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_STREAM = ST_STREAM,
        S_CLEAR = ST_CLEAR,
        S_WAIT_LOW = ST_WAIT_LOW
    } rd_state_t;

    // Row/col tag used by the checksum beat.
    localparam logic [1:0] CHK_IDX = 2'd3;

    typedef struct packed {
        logic [FP8_W-1:0] data;
        logic [1:0] row;
        logic [1:0] col;
        logic last;
    } rd_beat_t;

    function automatic logic [1:0] div3(input logic [3:0] v);
        logic [1:0] q;
        if (v >= 4'd9) q = 2'd3;
        else if (v >= 4'd6) q = 2'd2;
        else if (v >= 4'd3) q = 2'd1;
        else q = 2'd0;
        return q;
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] v);
        logic [3:0] t;
        t = v - ({2'b00, div3(v)} * 4'd3);
        return t[1:0];
    endfunction

    function automatic logic [3:0] rc_to_sel(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/matrix_rd_index.sv
// matrix_rd_index: maps a beat index to element select, row/col
// tags and the last flag for row- or column-major traversal.
module matrix_rd_index
    import matrix_pkg::*;
#(
    parameter int ORDER = 0,
    parameter bit CHK_EN = 1'b0
) (
    input  logic [3:0] i_idx,
    output logic [3:0] o_sel,
    output logic [1:0] o_row,
    output logic [1:0] o_col,
    output logic       o_last,
    output logic       o_is_chk
);

    localparam logic [3:0] LAST_IDX = CHK_EN ? 4'd9 : 4'd8;

    logic [1:0] w_q;
    logic [1:0] w_r;
    logic       w_chk;

    assign w_q = div3(i_idx);
    assign w_r = mod3(i_idx);
    assign w_chk = CHK_EN && (i_idx == 4'd9);

    // Decode the index into a row/col pair for the chosen order.
    always_comb begin
        o_sel = '0;
        o_row = '0;
        o_col = '0;
        o_is_chk = w_chk;
        unique case (1'b1)
            w_chk: begin
                o_row = CHK_IDX;
                o_col = CHK_IDX;
            end
            (!w_chk && ORDER == 0): begin
                o_row = w_q;
                o_col = w_r;
                o_sel = rc_to_sel(w_q, w_r);
            end
            default: begin
                o_row = w_r;
                o_col = w_q;
                o_sel = rc_to_sel(w_r, w_q);
            end
        endcase
    end

    assign o_last = (i_idx == LAST_IDX);

endmodule

// File: rtl/matrix_result_reader.sv
// matrix_result_reader: snapshots the 3x3 FP8 result matrix on done
// and streams it out. Optional checksum beat: MATRIX_RD_CHKSUM_EN.
module matrix_result_reader
    import matrix_pkg::*;
#(
    parameter int ORDER = 0,
    parameter int CLR_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done_in,
    input  logic [8:0] m1_in,
    input  logic [8:0] m2_in,
    input  logic [8:0] m3_in,
    input  logic [8:0] m4_in,
    input  logic [8:0] m5_in,
    input  logic [8:0] m6_in,
    input  logic [8:0] m7_in,
    input  logic [8:0] m8_in,
    input  logic [8:0] m9_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_row,
    output logic [1:0] out_col,
    output logic       out_last,
    output logic       busy,
    output logic       mat_clr
);

`ifdef MATRIX_RD_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam bit CHK_EN = 1'b0;
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    localparam logic [2:0] CLR_CNT = 3'(CLR_LEN);

    rd_state_t        r_state;
    logic             r_done_q;
    logic [FP8_W-1:0] r_snap [MAT_ELEMS];
    logic [3:0]       r_idx;
    logic [2:0]       r_clr_cnt;

    logic [FP8_W-1:0] w_in [MAT_ELEMS];
    logic [FP8_W-1:0] w_src [MAT_ELEMS];
    logic             w_rise;
    logic             w_idle;
    logic [3:0]       w_idx_nxt;
    logic [3:0]       w_sel;
    logic [1:0]       w_row;
    logic [1:0]       w_col;
    logic             w_last;
    logic             w_is_chk;
    rd_beat_t         w_beat;
    logic             w_unused;

    assign w_in[0] = m1_in[7:0];
    assign w_in[1] = m2_in[7:0];
    assign w_in[2] = m3_in[7:0];
    assign w_in[3] = m4_in[7:0];
    assign w_in[4] = m5_in[7:0];
    assign w_in[5] = m6_in[7:0];
    assign w_in[6] = m7_in[7:0];
    assign w_in[7] = m8_in[7:0];
    assign w_in[8] = m9_in[7:0];

    assign w_idle = (r_state == S_IDLE);
    assign w_rise = done_in && !r_done_q;
    assign w_idx_nxt = w_idle ? 4'd0 : r_idx + 4'd1;

    // In IDLE the next beat comes straight from the inputs being
    // captured; afterwards it comes from the snapshot.
    always_comb begin
        for (int i = 0; i < MAT_ELEMS; i++) begin
            w_src[i] = w_idle ? w_in[i] : r_snap[i];
        end
    end

    matrix_rd_index #(
        .ORDER  (ORDER),
        .CHK_EN (CHK_EN)
    ) u_index (
        .i_idx    (w_idx_nxt),
        .o_sel    (w_sel),
        .o_row    (w_row),
        .o_col    (w_col),
        .o_last   (w_last),
        .o_is_chk (w_is_chk)
    );

`ifdef MATRIX_RD_CHKSUM_EN
    logic [FP8_W-1:0] r_chk;
    logic [FP8_W-1:0] w_chk_in;

    // XOR of the incoming bytes, captured alongside the snapshot.
    always_comb begin
        w_chk_in = FP8_ZERO;
        for (int i = 0; i < MAT_ELEMS; i++) begin
            w_chk_in = w_chk_in ^ w_in[i];
        end
    end

    // Checksum register follows the snapshot load.
    always_ff @(posedge clk) begin
        if (!reset) r_chk <= FP8_ZERO;
        else if (w_idle && w_rise) r_chk <= w_chk_in;
    end

    // Assemble the next beat, substituting the checksum on beat 10.
    always_comb begin
        w_beat.data = w_src[w_sel];
        if (w_is_chk) w_beat.data = w_idle ? w_chk_in : r_chk;
        w_beat.row = w_row;
        w_beat.col = w_col;
        w_beat.last = w_last;
    end

    assign w_unused = ^{m1_in[8], m2_in[8], m3_in[8], m4_in[8],
                        m5_in[8], m6_in[8], m7_in[8], m8_in[8],
                        m9_in[8]};
`else
    // Assemble the next beat from the selected element.
    always_comb begin
        w_beat.data = w_src[w_sel];
        w_beat.row = w_row;
        w_beat.col = w_col;
        w_beat.last = w_last;
    end

    assign w_unused = ^{m1_in[8], m2_in[8], m3_in[8], m4_in[8],
                        m5_in[8], m6_in[8], m7_in[8], m8_in[8],
                        m9_in[8], w_is_chk};
`endif

    // Drain FSM: capture on done rise, stream, clear, wait for done low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_done_q <= 1'b1;
            r_idx <= 4'd0;
            r_clr_cnt <= 3'd0;
            for (int i = 0; i < MAT_ELEMS; i++) begin
                r_snap[i] <= FP8_ZERO;
            end
            out_valid <= 1'b0;
            out_data <= FP8_ZERO;
            out_row <= 2'd0;
            out_col <= 2'd0;
            out_last <= 1'b0;
            busy <= 1'b0;
            mat_clr <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done_q <= done_in;
                    if (w_rise) begin
                        for (int i = 0; i < MAT_ELEMS; i++) begin
                            r_snap[i] <= w_in[i];
                        end
                        r_idx <= w_idx_nxt;
                        out_valid <= 1'b1;
                        out_data <= w_beat.data;
                        out_row <= w_beat.row;
                        out_col <= w_beat.col;
                        out_last <= w_beat.last;
                        busy <= 1'b1;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last <= 1'b0;
                            mat_clr <= 1'b1;
                            r_clr_cnt <= 3'd1;
                            r_state <= S_CLEAR;
                        end else begin
                            r_idx <= w_idx_nxt;
                            out_data <= w_beat.data;
                            out_row <= w_beat.row;
                            out_col <= w_beat.col;
                            out_last <= w_beat.last;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == CLR_CNT) begin
                        mat_clr <= 1'b0;
                        r_state <= S_WAIT_LOW;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 3'd1;
                    end
                end
                S_WAIT_LOW: begin
                    if (!done_in) begin
                        r_done_q <= 1'b0;
                        busy <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
